ocm_port_arbiter: RTL and testbench
===================================

Name: ocm_port_arbiter

Overview:
- Two-master round-robin arbiter that shares one single-port 512x64 on-chip RAM (byte-enabled, 1-cycle read latency, unregistered q) between the camera frame writer (m0) and the HPS-bridge reader (m1).
- Presents two Avalon-MM-style slave ports with waitrequest and readdatavalid, and drives the RAM slave port.
- Tracks in-flight reads and returns each read word to the master that issued it.

Parameters:
- ADDR_W, 9, word address width.
- DATA_W, 64, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, cycles from accepted read to valid mem_readdata (1..4).

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- freeze  in  1  1 = stop granting new transfers; in-flight reads still complete.
- m0_address / m1_address  in  ADDR_W  word address.
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_writedata / m1_writedata  in  DATA_W  write data.
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle.
- m0_readdata / m1_readdata  out  DATA_W  returned read data.
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid this cycle.
- mem_address  out  ADDR_W  to RAM address.
- mem_byteenable  out  DATA_W/8  to RAM byteenable.
- mem_chipselect  out  1  to RAM chipselect.
- mem_write  out  1  to RAM write.
- mem_writedata  out  DATA_W  to RAM writedata.
- mem_clken  out  1  to RAM clken; tied 1 out of reset.
- mem_readdata  in  DATA_W  from RAM q.

Behaviour:
- Request: mX_req = mX_read | mX_write. If both read and write are asserted on one port, it is treated as a write; the read is ignored.
- Grant (combinational):
  - No grant while freeze=1 or reset_n=0.
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port not named in last_grant is granted.
  - last_grant register updates only on an accepted transfer. Reset value = m1, so m0 wins the first contention.
- mX_waitrequest = mX_req & ~grantX. Idle ports see waitrequest=0. A transfer is accepted in cycle N when req & ~waitrequest.
- Memory drive in accept cycle N:
  - mem_address, mem_byteenable and mem_writedata come from the granted port; mem_chipselect=1; mem_write = granted write.
  - No grant: mem_chipselect=0, mem_write=0, address/byteenable/writedata=0.
  - Reads drive mem_byteenable all-ones.
- Read tracking: a READ_LATENCY-deep shift pipeline of {valid, owner}, loaded at accept of a read and shifted every cycle.
  - At the pipeline tail (cycle N+READ_LATENCY), the owner's readdatavalid=1 and its readdata=mem_readdata.
  - Non-owner readdata=0, readdatavalid=0.
  - Back-to-back reads from alternating ports return in issue order, one word per cycle, with no bubbles.
- Writes produce no response. Write-then-read to the same address on consecutive cycles returns the new data; the RAM is write-before-read across cycles.
- freeze rising while reads are in flight: the pipeline keeps shifting, responses still delivered, no new accepts. freeze has no effect on mem_clken.
- Async reset (reset_n low at any time):
  - Pipeline cleared; in-flight reads are dropped with no readdatavalid.
  - last_grant=m1; mem_clken=0 while in reset, then 1.
  - All waitrequest=1 while in reset; all other outputs 0.
- Throughput: 1 transfer per cycle aggregate. With both ports continuously requesting, grants alternate m0,m1,m0,...

Test Plan:
- After reset release, m0 writes addr 0x005 = 0x1122334455667788 with be=0xFF, then m1 reads 0x005 → m1_readdatavalid exactly 1 cycle after accept, m1_readdata = 0x1122334455667788, m0_readdatavalid stays 0.
- m0 and m1 both read continuously from cycle 0 (m0 addr 0x010.., m1 addr 0x100..) → grants alternate m0,m1,m0,m1; each port sees waitrequest every other cycle; returned data matches the addresses in order.
- Byte lanes: m1 writes 0xFFFFFFFFFFFFFFFF to 0x1FF with be=0xFF, then m0 writes 0 to 0x1FF with be=0x0F → a read of 0x1FF returns 0xFFFFFFFF00000000.
- freeze=1 in the cycle after m0's read accept, with m1 requesting → m0 still gets readdatavalid; m1 waitrequest stays 1 until freeze=0, then m1 is granted the next cycle.
- reset_n pulsed low the cycle after a read accept (READ_LATENCY=2 build) → no readdatavalid is ever produced for that read; after release, m0 wins the first contention.
- m0 asserts read and write together to 0x020 with data 0xA5 → RAM is written 0xA5 and no readdatavalid follows.

Source files
------------

// File: rtl/ocm_port_arbiter.sv
// Two-master round-robin arbiter in front of a single-port byte-enabled RAM.
// Read responses are steered back to the issuing port through a latency-matched owner pipeline.
module ocm_port_arbiter #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                freeze,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);
    localparam int BE_W = DATA_W / 8;

    logic [1:0]                   req;
    logic [1:0]                   wr;
    logic [1:0]                   grant;
    logic [1:0][ADDR_W-1:0]       addr_p;
    logic [1:0][BE_W-1:0]         be_p;
    logic [1:0][DATA_W-1:0]       wd_p;

    // last_grant_q: 0 = m0 won last, 1 = m1 won last
    logic last_grant_q, last_grant_d;
    logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [READ_LATENCY-1:0] own_pipe_q, own_pipe_d;

    logic sel;
    logic tail_vld, tail_own;

    assign req    = {m1_read | m1_write, m0_read | m0_write};
    assign wr     = {m1_write, m0_write};
    assign addr_p = {m1_address, m0_address};
    assign be_p   = {m1_byteenable, m0_byteenable};
    assign wd_p   = {m1_writedata, m0_writedata};

    always_comb begin
        grant = 2'b00;
        if (reset_n && !freeze) begin
            if (req == 2'b11) grant = last_grant_q ? 2'b01 : 2'b10;
            else              grant = req;
        end
    end

    assign sel = grant[1];

    always_comb begin
        mem_chipselect = |grant;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        if (|grant) begin
            mem_write     = wr[sel];
            mem_address   = addr_p[sel];
            mem_writedata = wd_p[sel];
            // A read always fetches the whole word; lane selection is the master's business.
            mem_byteenable = wr[sel] ? be_p[sel] : {BE_W{1'b1}};
        end
    end

    // Write wins when a port raises read and write together, so it never enters the read pipe.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant[1])      last_grant_d = 1'b1;
        else if (grant[0]) last_grant_d = 1'b0;
        vld_pipe_d    = '0;
        own_pipe_d    = '0;
        vld_pipe_d[0] = (|grant) & ~wr[sel];
        own_pipe_d[0] = sel;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            own_pipe_d[i] = own_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            vld_pipe_q   <= '0;
            own_pipe_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            vld_pipe_q   <= vld_pipe_d;
            own_pipe_q   <= own_pipe_d;
        end
    end

    assign tail_vld = vld_pipe_q[READ_LATENCY-1];
    assign tail_own = own_pipe_q[READ_LATENCY-1];

    assign m0_readdatavalid = tail_vld & ~tail_own;
    assign m1_readdatavalid = tail_vld & tail_own;
    assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
    assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

    assign m0_waitrequest = ~reset_n | (req[0] & ~grant[0]);
    assign m1_waitrequest = ~reset_n | (req[1] & ~grant[1]);

    assign mem_clken = reset_n;

endmodule

// File: tb/tb_ocm_port_arbiter.sv
// Directed bench: READ_LATENCY=1 (a_*) and READ_LATENCY=2 (b_*) instances share one stimulus,
// each backed by its own behavioural RAM with matching read latency.
module tb_ocm_port_arbiter;
    logic clk;
    logic reset_n, freeze;
    logic [8:0]  m0_address, m1_address;
    logic [7:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [63:0] m0_writedata, m1_writedata;

    logic        a_m0_wait, a_m1_wait, a_m0_rdv, a_m1_rdv;
    logic [63:0] a_m0_rd, a_m1_rd;
    logic [8:0]  a_mem_address;
    logic [7:0]  a_mem_be;
    logic        a_mem_cs, a_mem_write, a_mem_clken;
    logic [63:0] a_mem_wd, a_mem_rd;

    logic        b_m0_wait, b_m1_wait, b_m0_rdv, b_m1_rdv;
    logic [63:0] b_m0_rd, b_m1_rd;
    logic [8:0]  b_mem_address;
    logic [7:0]  b_mem_be;
    logic        b_mem_cs, b_mem_write, b_mem_clken;
    logic [63:0] b_mem_wd, b_mem_rd, b_q1;

    int n_chk  = 0;
    int n_pass = 0;

    ocm_port_arbiter #(.ADDR_W(9), .DATA_W(64), .READ_LATENCY(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .freeze(freeze),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(a_m0_wait),
        .m0_readdata(a_m0_rd), .m0_readdatavalid(a_m0_rdv),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(a_m1_wait),
        .m1_readdata(a_m1_rd), .m1_readdatavalid(a_m1_rdv),
        .mem_address(a_mem_address), .mem_byteenable(a_mem_be), .mem_chipselect(a_mem_cs),
        .mem_write(a_mem_write), .mem_writedata(a_mem_wd), .mem_clken(a_mem_clken),
        .mem_readdata(a_mem_rd)
    );

    ocm_port_arbiter #(.ADDR_W(9), .DATA_W(64), .READ_LATENCY(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .freeze(freeze),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(b_m0_wait),
        .m0_readdata(b_m0_rd), .m0_readdatavalid(b_m0_rdv),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(b_m1_wait),
        .m1_readdata(b_m1_rd), .m1_readdatavalid(b_m1_rdv),
        .mem_address(b_mem_address), .mem_byteenable(b_mem_be), .mem_chipselect(b_mem_cs),
        .mem_write(b_mem_write), .mem_writedata(b_mem_wd), .mem_clken(b_mem_clken),
        .mem_readdata(b_mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Unwritten words read back a recognisable address-derived pattern.
    function automatic logic [63:0] pat(input logic [8:0] a);
        return 64'hC0DE_0000_0000_0000 | {55'd0, a};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    logic [63:0] ram_a [512];
    logic        wrt_a [512];
    logic [63:0] ram_b [512];
    logic        wrt_b [512];

    always @(posedge clk) begin
        if (a_mem_clken && a_mem_cs) begin
            if (a_mem_write) begin
                ram_a[a_mem_address] <= merge(wrt_a[a_mem_address] ? ram_a[a_mem_address]
                                              : pat(a_mem_address), a_mem_wd, a_mem_be);
                wrt_a[a_mem_address] <= 1'b1;
            end else begin
                a_mem_rd <= wrt_a[a_mem_address] ? ram_a[a_mem_address] : pat(a_mem_address);
            end
        end
    end

    always @(posedge clk) begin
        if (b_mem_clken && b_mem_cs) begin
            if (b_mem_write) begin
                ram_b[b_mem_address] <= merge(wrt_b[b_mem_address] ? ram_b[b_mem_address]
                                              : pat(b_mem_address), b_mem_wd, b_mem_be);
                wrt_b[b_mem_address] <= 1'b1;
            end else begin
                b_q1 <= wrt_b[b_mem_address] ? ram_b[b_mem_address] : pat(b_mem_address);
            end
        end
        b_mem_rd <= b_q1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, act, exp);
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            wrt_a[i] = 1'b0;
            wrt_b[i] = 1'b0;
        end
        a_mem_rd = '0; b_mem_rd = '0; b_q1 = '0;
        reset_n = 1'b1; freeze = 1'b0;
        idle();
        #1 reset_n = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_m0_wait", a_m0_wait, 1);
        check("rst_m1_wait", b_m1_wait, 1);
        check("rst_clken",   a_mem_clken, 0);
        check("rst_cs",      a_mem_cs, 0);
        check("rst_rdv",     a_m0_rdv, 0);
        next_cycle();
        reset_n = 1'b1;

        // m0 write, then m1 read-back
        next_cycle();
        m0_write = 1; m0_address = 9'h005; m0_writedata = 64'h1122334455667788; m0_byteenable = 8'hFF;
        @(negedge clk);
        check("w_m0_wait", a_m0_wait, 0);
        check("w_clken",   a_mem_clken, 1);
        check("w_cs",      a_mem_cs, 1);
        check("w_we",      a_mem_write, 1);
        check("w_addr",    a_mem_address, 9'h005);
        check("w_wd",      a_mem_wd, 64'h1122334455667788);
        next_cycle();
        idle();
        m1_read = 1; m1_address = 9'h005; m1_byteenable = 8'h00;
        @(negedge clk);
        check("r_m1_wait", a_m1_wait, 0);
        check("r_we",      a_mem_write, 0);
        check("r_be",      a_mem_be, 8'hFF);
        next_cycle();
        idle();
        @(negedge clk);
        check("r_m1_rdv",  a_m1_rdv, 1);
        check("r_m1_data", a_m1_rd, 64'h1122334455667788);
        check("r_m0_rdv",  a_m0_rdv, 0);
        check("r_m0_data", a_m0_rd, 0);
        check("r_b_early", b_m1_rdv, 0);
        next_cycle();
        @(negedge clk);
        check("r_b_rdv",   b_m1_rdv, 1);
        check("r_b_data",  b_m1_rd, 64'h1122334455667788);
        check("r_a_late",  a_m1_rdv, 0);

        // both ports reading continuously: m0 wins even cycles
        for (int c = 0; c <= 8; c++) begin
            next_cycle();
            if (c < 8) begin
                m0_read = 1; m0_address = 9'h010 + 9'((c + 1) / 2);
                m1_read = 1; m1_address = 9'h100 + 9'(c / 2);
            end else idle();
            @(negedge clk);
            if (c < 8) begin
                check($sformatf("rr_m0_wait%0d", c), a_m0_wait, (c % 2 == 1));
                check($sformatf("rr_m1_wait%0d", c), a_m1_wait, (c % 2 == 0));
            end
            if (c > 0) begin
                if ((c - 1) % 2 == 0) begin
                    check($sformatf("rr_m0_rdv%0d", c), a_m0_rdv, 1);
                    check($sformatf("rr_m0_dat%0d", c), a_m0_rd, pat(9'h010 + 9'((c - 1) / 2)));
                    check($sformatf("rr_m1_rdv%0d", c), a_m1_rdv, 0);
                end else begin
                    check($sformatf("rr_m1_rdv%0d", c), a_m1_rdv, 1);
                    check($sformatf("rr_m1_dat%0d", c), a_m1_rd, pat(9'h100 + 9'((c - 1) / 2)));
                    check($sformatf("rr_m0_rdv%0d", c), a_m0_rdv, 0);
                end
            end
        end

        // byte lanes
        next_cycle();
        m1_write = 1; m1_address = 9'h1FF; m1_writedata = '1; m1_byteenable = 8'hFF;
        next_cycle();
        idle();
        m0_write = 1; m0_address = 9'h1FF; m0_writedata = '0; m0_byteenable = 8'h0F;
        @(negedge clk);
        check("be_mem_be", a_mem_be, 8'h0F);
        next_cycle();
        idle();
        m0_read = 1; m0_address = 9'h1FF;
        next_cycle();
        idle();
        @(negedge clk);
        check("be_rdv",  a_m0_rdv, 1);
        check("be_data", a_m0_rd, 64'hFFFFFFFF00000000);

        // freeze with a read in flight
        next_cycle();
        m0_read = 1; m0_address = 9'h010;
        @(negedge clk);
        check("fz_acc", a_m0_wait, 0);
        next_cycle();
        idle();
        freeze = 1; m1_read = 1; m1_address = 9'h101;
        @(negedge clk);
        check("fz_m0_rdv",  a_m0_rdv, 1);
        check("fz_m0_data", a_m0_rd, pat(9'h010));
        check("fz_m1_wait", a_m1_wait, 1);
        check("fz_cs",      a_mem_cs, 0);
        check("fz_clken",   a_mem_clken, 1);
        next_cycle();
        @(negedge clk);
        check("fz_m1_wait2", a_m1_wait, 1);
        check("fz_b_m0_rdv", b_m0_rdv, 1);
        next_cycle();
        freeze = 0;
        @(negedge clk);
        check("fz_m1_go", a_m1_wait, 0);
        next_cycle();
        idle();
        @(negedge clk);
        check("fz_m1_rdv",  a_m1_rdv, 1);
        check("fz_m1_data", a_m1_rd, pat(9'h101));

        // read+write together is a write
        next_cycle();
        m0_read = 1; m0_write = 1; m0_address = 9'h020; m0_writedata = 64'hA5; m0_byteenable = 8'hFF;
        @(negedge clk);
        check("rw_we", a_mem_write, 1);
        check("rw_wd", a_mem_wd, 64'hA5);
        next_cycle();
        idle();
        @(negedge clk);
        check("rw_no_rdv_a", a_m0_rdv, 0);
        next_cycle();
        m0_read = 1; m0_address = 9'h020;
        @(negedge clk);
        check("rw_no_rdv_b", b_m0_rdv, 0);
        next_cycle();
        idle();
        @(negedge clk);
        check("rw_rd_data", a_m0_rd, 64'hA5);

        // reset pulse with a read in flight (READ_LATENCY=2 instance)
        next_cycle();
        next_cycle();
        m0_read = 1; m0_address = 9'h030;
        @(negedge clk);
        check("rs_acc", b_m0_wait, 0);
        next_cycle();
        idle();
        m0_read = 1; m0_address = 9'h030;
        reset_n = 0;
        @(negedge clk);
        check("rs_rdv_a",  a_m0_rdv, 0);
        check("rs_rdv_b1", b_m0_rdv, 0);
        check("rs_wait",   b_m0_wait, 1);
        check("rs_clken",  b_mem_clken, 0);
        check("rs_cs",     b_mem_cs, 0);
        next_cycle();
        @(negedge clk);
        check("rs_rdv_b2", b_m0_rdv, 0);
        next_cycle();
        reset_n = 1;
        m0_read = 1; m0_address = 9'h031;
        m1_read = 1; m1_address = 9'h131;
        @(negedge clk);
        check("rs_m0_wins", b_m0_wait, 0);
        check("rs_m1_waits", b_m1_wait, 1);
        check("rs_rdv_b3", b_m0_rdv, 0);
        next_cycle();
        idle();
        @(negedge clk);
        check("rs_rdv_b4", b_m0_rdv, 0);
        next_cycle();
        @(negedge clk);
        check("rs_b_rdv",  b_m0_rdv, 1);
        check("rs_b_data", b_m0_rd, pat(9'h031));

        next_cycle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
